pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter HOLD_CYCLES, default 8: cycles level_out stays high per accepted event; SHALL be >= 1.
REQ-002 Parameter GAP_CYCLES, default 2: minimum low cycles between stretched outputs; 0 allowed.
REQ-003 Parameter RETRIGGER, default 0: 1 = a pulse during HOLD restarts the hold timer.
REQ-004 Parameter PEND_MAX, default 3: saturation limit of the pending-event counter; SHALL be >= 1.
REQ-005 Parameter CNT_W, default 8: width of event_cnt.
REQ-006 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 pulse_in  input  1  single-cycle event from the button-shaper output; each sampled high cycle is one event.
REQ-009 level_out  output  1  registered stretched level.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 pend_cnt  output  clog2(PEND_MAX+1)  queued events awaiting output.
REQ-012 event_cnt  output  CNT_W  accepted events, wrapping modulo 2^CNT_W.
REQ-013 dropped  output  1  sticky; set when an event is lost to pending saturation.

Function
REQ-014 FSM states: IDLE, HOLD, GAP; level_out SHALL be 1 exactly in HOLD.
REQ-015 IDLE and pulse_in=1 -> HOLD on the sampling edge, so level_out is high from the next cycle; timer loaded with HOLD_CYCLES.
REQ-016 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to GAP, or to IDLE/next HOLD directly when GAP_CYCLES=0.
REQ-017 GAP SHALL last exactly GAP_CYCLES cycles; at exit: pend_cnt>0 -> decrement and enter HOLD; otherwise IDLE.
REQ-018 RETRIGGER=1, pulse_in in HOLD: reload timer to HOLD_CYCLES, leaving level high HOLD_CYCLES cycles after that pulse's sampling edge; no pending increment.
REQ-019 RETRIGGER=0 in HOLD, or any mode in GAP: pulse_in increments pend_cnt if below PEND_MAX; otherwise set dropped, pend_cnt unchanged.
REQ-020 Pulse on the final GAP cycle: the increment and the consume SHALL be combined, so pend_cnt changes net 0 and no drop occurs even at PEND_MAX.
REQ-021 With GAP_CYCLES=0, the same combine rule SHALL apply on the final HOLD cycle.
REQ-022 event_cnt SHALL increment for every pulse_in that starts, retriggers or is queued, and SHALL NOT increment for dropped events; wraps from all-ones to 0.
REQ-023 pulse_in held high for N consecutive cycles SHALL count as N events; no edge detection is performed here.

Reset
REQ-024 While rst=1 at an edge: state IDLE, level_out=0, busy=0, pend_cnt=0, event_cnt=0, dropped=0, timer=0; pulse_in SHALL be ignored.
REQ-025 rst asserted mid-HOLD or mid-GAP SHALL abort immediately (outputs low on the following cycle); queued events are discarded.
REQ-026 The first edge with rst=0 SHALL sample pulse_in normally.

Structure
REQ-027 Shared package pulse_stretcher_pkg SHALL hold the state typedef (IDLE/HOLD/GAP) and the default parameter constants.
REQ-028 One sub-module, cycle_timer: loadable down-counter with load value, load strobe, and a last-cycle flag; shared by HOLD and GAP and sized clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
REQ-029 All outputs SHALL be registered; there is no combinational path from pulse_in to any output.

Verification (defaults unless stated; cycle n = edge n)
REQ-030 Single pulse at 10 -> level_out high 11..18; busy high 11..20; event_cnt=1; IDLE at 21.
REQ-031 RETRIGGER=1, pulses at 0 and 5 -> level_out high 1..13 continuously; event_cnt=2; pend_cnt stays 0.
REQ-032 RETRIGGER=0, pulses at 0, 3, 4 -> level_out high 1..8, 11..18, 21..28; pend_cnt peaks at 2; event_cnt=3.
REQ-033 Five pulses at 0..4 -> pend_cnt=3, dropped=1, event_cnt=4; four separate stretched outputs, last high 31..38.
REQ-034 Pulse at 0, then pulse on the final GAP cycle 10 -> HOLD 11..18 with pend_cnt 0 throughout; dropped=0.
REQ-035 rst at cycle 4 of HOLD with pend_cnt=2 and pulse_in high -> all outputs 0 the next cycle; the next pulse after reset starts a fresh HOLD.

Source files
------------

// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default parameter values for the pulse stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned DEF_HOLD_CYCLES = 8;
    localparam int unsigned DEF_GAP_CYCLES  = 2;
    localparam int unsigned DEF_RETRIGGER   = 0;
    localparam int unsigned DEF_PEND_MAX    = 3;
    localparam int unsigned DEF_CNT_W       = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// Loadable down-counter; last_o flags the final cycle of a loaded interval.
module cycle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed-length levels separated by a
// minimum gap, queuing (or retriggering on) events that arrive while busy.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned RETRIGGER   = DEF_RETRIGGER,
    parameter int unsigned PEND_MAX    = DEF_PEND_MAX,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pulse_in,
    output logic                             level_out,
    output logic                             busy,
    output logic [$clog2(PEND_MAX+1)-1:0]    pend_cnt,
    output logic [CNT_W-1:0]                 event_cnt,
    output logic                             dropped
);

    localparam int unsigned PW = $clog2(PEND_MAX + 1);
    localparam int unsigned TW = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES);
    localparam logic [PW-1:0] PEND_LIM = PW'(PEND_MAX);

    state_e            state_q, state_d;
    logic [PW-1:0]     pend_q, pend_d;
    logic [CNT_W-1:0]  evt_q, evt_d;
    logic              drop_q, drop_d;
    logic              level_q, busy_q;
    logic              tmr_load, tmr_last;
    logic [TW-1:0]     tmr_val;

    cycle_timer #(.W(TW)) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .last_o     (tmr_last)
    );

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        evt_d    = evt_q;
        drop_d   = drop_q;
        tmr_load = 1'b0;
        tmr_val  = HOLD_LD;
        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    evt_d    = evt_q + CNT_W'(1);
                end
            end
            HOLD, GAP: begin
                if (state_q == HOLD && RETRIGGER != 0 && pulse_in) begin
                    tmr_load = 1'b1;
                    evt_d    = evt_q + CNT_W'(1);
                end else if (tmr_last && (state_q == GAP || GAP_CYCLES == 0)) begin
                    // A pulse on the exit cycle is queued and consumed at once:
                    // pend_cnt is untouched and saturation cannot drop it.
                    if (pend_q != '0 || pulse_in) begin
                        state_d  = HOLD;
                        tmr_load = 1'b1;
                        if (pulse_in) begin
                            evt_d = evt_q + CNT_W'(1);
                        end else begin
                            pend_d = pend_q - PW'(1);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (tmr_last) begin
                        state_d  = GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_LD;
                    end
                    if (pulse_in) begin
                        if (pend_q != PEND_LIM) begin
                            pend_d = pend_q + PW'(1);
                            evt_d  = evt_q + CNT_W'(1);
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            evt_q   <= '0;
            drop_q  <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            evt_q   <= evt_d;
            drop_q  <= drop_d;
            level_q <= (state_d == HOLD);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign pend_cnt  = pend_q;
    assign event_cnt = evt_q;
    assign dropped   = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: three parameterisations checked every cycle
// against a timestamp-based reference, plus vector tables and corner sequences.
module tb_pulse_stretcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic pulse_in = 1'b0;

    logic       lvl0, busy0, drop0;
    logic [1:0] pend0;
    logic [7:0] evt0;
    logic       lvl1, busy1, drop1;
    logic [1:0] pend1;
    logic [2:0] evt1;
    logic       lvl2, busy2, drop2;
    logic [1:0] pend2;
    logic [3:0] evt2;

    pulse_stretcher #(.HOLD_CYCLES(8), .GAP_CYCLES(2), .RETRIGGER(0), .PEND_MAX(3), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .level_out(lvl0), .busy(busy0),
        .pend_cnt(pend0), .event_cnt(evt0), .dropped(drop0));

    pulse_stretcher #(.HOLD_CYCLES(8), .GAP_CYCLES(2), .RETRIGGER(1), .PEND_MAX(3), .CNT_W(3)) u1 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .level_out(lvl1), .busy(busy1),
        .pend_cnt(pend1), .event_cnt(evt1), .dropped(drop1));

    pulse_stretcher #(.HOLD_CYCLES(3), .GAP_CYCLES(0), .RETRIGGER(0), .PEND_MAX(2), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .level_out(lvl2), .busy(busy2),
        .pend_cnt(pend2), .event_cnt(evt2), .dropped(drop2));

    int P_H[3]  = '{8, 8, 3};
    int P_G[3]  = '{2, 2, 0};
    int P_R[3]  = '{0, 1, 0};
    int P_PM[3] = '{3, 3, 2};
    int P_CW[3] = '{8, 3, 4};

    int checks = 0;
    int failures = 0;
    int t = 0;

    // Reference: last edge index of HOLD / GAP for the current stretched output.
    int hold_end[3], gap_end[3], m_pend[3], m_evt[3], m_drop[3];
    int e_lvl[3], e_busy[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", nm, t, act, exp);
        end
    endtask

    task automatic m_start(input int i, input bit count);
        hold_end[i] = t + P_H[i];
        gap_end[i]  = t + P_H[i] + P_G[i];
        if (count) m_evt[i] = (m_evt[i] + 1) % (1 << P_CW[i]);
    endtask

    task automatic m_enqueue(input int i);
        if (m_pend[i] < P_PM[i]) begin
            m_pend[i]++;
            m_evt[i] = (m_evt[i] + 1) % (1 << P_CW[i]);
        end else begin
            m_drop[i] = 1;
        end
    endtask

    task automatic m_exit(input int i, input bit p);
        if (p) m_start(i, 1'b1);
        else if (m_pend[i] > 0) begin
            m_pend[i]--;
            m_start(i, 1'b0);
        end
    endtask

    task automatic model_edge(input int i, input bit p, input bit r);
        if (r) begin
            hold_end[i] = t; gap_end[i] = t;
            m_pend[i] = 0; m_evt[i] = 0; m_drop[i] = 0;
        end else if (t > gap_end[i]) begin
            if (p) m_start(i, 1'b1);
        end else if (t <= hold_end[i]) begin
            if (P_R[i] != 0 && p) m_start(i, 1'b1);
            else if (t == hold_end[i] && P_G[i] == 0) m_exit(i, p);
            else if (p) m_enqueue(i);
        end else begin
            if (t == gap_end[i]) m_exit(i, p);
            else if (p) m_enqueue(i);
        end
        e_lvl[i]  = (t + 1 <= hold_end[i]) ? 1 : 0;
        e_busy[i] = (t + 1 <= gap_end[i]) ? 1 : 0;
    endtask

    task automatic compare_all();
        chk("u0.level_out", lvl0, e_lvl[0]);  chk("u0.busy", busy0, e_busy[0]);
        chk("u0.pend_cnt", pend0, m_pend[0]); chk("u0.event_cnt", evt0, m_evt[0]);
        chk("u0.dropped", drop0, m_drop[0]);
        chk("u1.level_out", lvl1, e_lvl[1]);  chk("u1.busy", busy1, e_busy[1]);
        chk("u1.pend_cnt", pend1, m_pend[1]); chk("u1.event_cnt", evt1, m_evt[1]);
        chk("u1.dropped", drop1, m_drop[1]);
        chk("u2.level_out", lvl2, e_lvl[2]);  chk("u2.busy", busy2, e_busy[2]);
        chk("u2.pend_cnt", pend2, m_pend[2]); chk("u2.event_cnt", evt2, m_evt[2]);
        chk("u2.dropped", drop2, m_drop[2]);
    endtask

    task automatic step(input bit p, input bit r);
        @(negedge clk);
        pulse_in = p;
        rst = r;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i, p, r);
        #1;
        compare_all();
        t++;
    endtask

    typedef struct {
        bit rst;
        bit pulse;
        int reps;
        bit lvl;
        bit busy;
        int pend;
        int evt;
        bit drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit p, input int n, input bit l, input bit b,
                       input int pd, input int ev, input bit d);
        vec_t v;
        v.rst = r; v.pulse = p; v.reps = n; v.lvl = l; v.busy = b;
        v.pend = pd; v.evt = ev; v.drop = d;
        tbl.push_back(v);
    endtask

    initial begin
        int dens;

        // Queued pulses at 0, 3, 4 (default config), then five back-to-back pulses.
        add(1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 1, 0);
        add(0, 0, 2, 1, 1, 0, 1, 0);
        add(0, 1, 1, 1, 1, 1, 2, 0);
        add(0, 1, 4, 1, 1, 2, 3, 0);
        add(0, 0, 2, 0, 1, 2, 3, 0);
        add(0, 0, 8, 1, 1, 1, 3, 0);
        add(0, 0, 2, 0, 1, 1, 3, 0);
        add(0, 0, 8, 1, 1, 0, 3, 0);
        add(0, 0, 2, 0, 1, 0, 3, 0);
        add(0, 0, 3, 0, 0, 0, 3, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 1, 0);
        add(0, 1, 1, 1, 1, 1, 2, 0);
        add(0, 1, 1, 1, 1, 2, 3, 0);
        add(0, 1, 1, 1, 1, 3, 4, 0);
        add(0, 1, 4, 1, 1, 3, 4, 1);
        add(0, 0, 2, 0, 1, 3, 4, 1);
        add(0, 0, 8, 1, 1, 2, 4, 1);
        add(0, 0, 2, 0, 1, 2, 4, 1);
        add(0, 0, 8, 1, 1, 1, 4, 1);
        add(0, 0, 2, 0, 1, 1, 4, 1);
        add(0, 0, 8, 1, 1, 0, 4, 1);
        add(0, 0, 2, 0, 1, 0, 4, 1);
        add(0, 0, 3, 0, 0, 0, 4, 1);

        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("reset.level_out", lvl0, 0); chk("reset.busy", busy0, 0);
        chk("reset.pend_cnt", pend0, 0); chk("reset.event_cnt", evt0, 0);
        chk("reset.dropped", drop0, 0);

        foreach (tbl[j]) begin
            for (int n = 0; n < tbl[j].reps; n++) begin
                step((n == 0) ? tbl[j].pulse : 1'b0, tbl[j].rst);
                chk("tbl.level_out", lvl0, tbl[j].lvl);
                chk("tbl.busy", busy0, tbl[j].busy);
                chk("tbl.pend_cnt", pend0, tbl[j].pend);
                chk("tbl.event_cnt", evt0, tbl[j].evt);
                chk("tbl.dropped", drop0, tbl[j].drop);
            end
        end

        // Single pulse sampled at relative edge 10.
        step(1'b0, 1'b1);
        for (int k = 0; k < 22; k++) begin
            step(k == 10, 1'b0);
            if (k >= 10) begin
                chk("single.level_out", lvl0, (k <= 17) ? 1 : 0);
                chk("single.busy", busy0, (k <= 19) ? 1 : 0);
            end
        end
        chk("single.event_cnt", evt0, 1);

        // Retrigger extends the hold continuously.
        step(1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step(k == 0 || k == 5, 1'b0);
            chk("retrig.level_out", lvl1, (k <= 12) ? 1 : 0);
            chk("retrig.pend_cnt", pend1, 0);
        end
        chk("retrig.event_cnt", evt1, 2);

        // Pulse on the final GAP cycle starts the next HOLD with pend_cnt unchanged.
        step(1'b0, 1'b1);
        for (int k = 0; k < 22; k++) begin
            step(k == 0 || k == 10, 1'b0);
            if (k >= 10 && k <= 17) begin
                chk("gapexit.level_out", lvl0, 1);
                chk("gapexit.pend_cnt", pend0, 0);
            end
        end
        chk("gapexit.dropped", drop0, 0);
        chk("gapexit.event_cnt", evt0, 2);

        // Same combine at pending saturation: no drop.
        step(1'b0, 1'b1);
        for (int k = 0; k <= 10; k++) step(k <= 3 || k == 10, 1'b0);
        chk("gapsat.pend_cnt", pend0, 3);
        chk("gapsat.dropped", drop0, 0);
        chk("gapsat.event_cnt", evt0, 5);
        chk("gapsat.level_out", lvl0, 1);
        for (int k = 0; k < 45; k++) step(1'b0, 1'b0);

        // GAP_CYCLES=0: combine on the final HOLD cycle while saturated.
        step(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        chk("nogap.pend_cnt", pend2, 2);
        chk("nogap.dropped", drop2, 0);
        chk("nogap.level_out", lvl2, 1);
        chk("nogap.event_cnt", evt2, 4);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0);

        // Reset mid-HOLD with events queued and pulse_in high.
        step(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        chk("abort.pre_pend", pend0, 2);
        step(1'b1, 1'b1);
        chk("abort.level_out", lvl0, 0); chk("abort.busy", busy0, 0);
        chk("abort.pend_cnt", pend0, 0); chk("abort.event_cnt", evt0, 0);
        chk("abort.dropped", drop0, 0);
        step(1'b1, 1'b0);
        chk("abort.restart_level", lvl0, 1); chk("abort.restart_evt", evt0, 1);
        chk("abort.restart_pend", pend0, 0);

        // Randomized traffic with varying density and occasional resets.
        dens = 20;
        for (int k = 0; k < 4000; k++) begin
            if (k % 150 == 0) begin
                case ($urandom_range(0, 2))
                    0: dens = 4;
                    1: dens = 25;
                    default: dens = 70;
                endcase
            end
            step($urandom_range(0, 99) < dens, $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
